// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one sha256XMSS core among N_REQ requesters.
// Store/continue midstate sequences lock the core to one requester until released.
module hash_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_start,
  input  logic [N_REQ*DATA_W-1:0]   req_data_in,
  input  logic [N_REQ-1:0]          req_message_length,
  input  logic [N_REQ-1:0]          req_continue_intermediate,
  input  logic [N_REQ-1:0]          req_store_intermediate,
  output logic [N_REQ-1:0]          req_done,
  output logic [N_REQ-1:0]          grant,
  output logic                      hash_start,
  output logic [DATA_W-1:0]         hash_data_in,
  output logic                      hash_message_length,
  output logic                      hash_continue_intermediate,
  output logic                      hash_store_intermediate,
  input  logic                      hash_done,
  output logic                      busy,
  output logic                      locked,
  output logic                      protocol_err
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  grant_s, start_bad_s, start_ok_s;
  logic              win_found_s;
  logic [ID_W-1:0]   win_id_s, cand_s;
  logic [ID_W:0]     sum_s;
  logic [DATA_W-1:0] data_arr_s [N_REQ];

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr_s[g] = req_data_in[g*DATA_W +: DATA_W];
  end

  assign grant_s     = (state_q != S_IDLE) ? id_to_onehot(grant_id_q) : {N_REQ{1'b0}};
  // A start from a requester that is already queued or currently owns the core is dropped.
  assign start_bad_s = req_start & (pending_q | grant_s);
  assign start_ok_s  = req_start & ~start_bad_s;

  // Round-robin search from rr_ptr+1; a held lock masks out everyone but its owner.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    sum_s       = {(ID_W+1){1'b0}};
    cand_s      = {ID_W{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(N_REQ)) begin
        cand_s = ID_W'(sum_s - (ID_W+1)'(N_REQ));
      end else begin
        cand_s = sum_s[ID_W-1:0];
      end
      if (!win_found_s && pending_q[cand_s] && (!locked_q || (cand_s == lock_id_q))) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Core-side mux driven from the registered owner; quiet while idle.
  always_comb begin
    if (state_q != S_IDLE) begin
      hash_data_in               = data_arr_s[grant_id_q];
      hash_message_length        = req_message_length[grant_id_q];
      hash_continue_intermediate = req_continue_intermediate[grant_id_q];
      hash_store_intermediate    = req_store_intermediate[grant_id_q];
    end else begin
      hash_data_in               = {DATA_W{1'b0}};
      hash_message_length        = 1'b0;
      hash_continue_intermediate = 1'b0;
      hash_store_intermediate    = 1'b0;
    end
  end

  // Transaction sequencing, pending bookkeeping and lock update at completion.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_id_d  = lock_id_q;
    pending_d  = pending_q | start_ok_s;
    err_d      = err_q | (|start_bad_s);
    req_done   = {N_REQ{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d    = S_ISSUE;
          grant_id_d = win_id_s;
          pending_d  = (pending_q & ~id_to_onehot(win_id_s)) | start_ok_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (hash_done) begin
          state_d  = S_IDLE;
          req_done = grant_s;
          rr_ptr_d = grant_id_q;
          if (hash_store_intermediate) begin
            locked_d  = 1'b1;
            lock_id_d = grant_id_q;
          end else if (locked_q && hash_continue_intermediate) begin
            locked_d = 1'b0;
          end else begin
            locked_d = locked_q;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pending_q  <= {N_REQ{1'b0}};
      grant_id_q <= {ID_W{1'b0}};
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      lock_id_q  <= {ID_W{1'b0}};
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign grant        = grant_s;
  assign hash_start   = (state_q == S_ISSUE);
  assign busy         = (state_q != S_IDLE) || (|pending_q);
  assign locked       = locked_q;
  assign protocol_err = err_q;

endmodule
